// File: rtl/soc_addr_map_pkg.sv
// Shared types and constants for the runtime-programmable SoC address map.
// Holds the rule record, the config-port register addresses, the config FSM
// state type and the reset-time SoC memory map (Debug .. DRAM).
package soc_addr_map_pkg;

    // Rule fields are stored at the widest supported address width; the
    // decoder slices them down to its own AddrWidth.
    localparam int unsigned MaxAddrWidth = 64;
    localparam int unsigned NumSocRules  = 11;

    typedef struct packed {
        logic [MaxAddrWidth-1:0] base;
        logic [MaxAddrWidth-1:0] len;
        logic                    en;
    } rule_t;

    // Config register word addresses (rule r: base at 2r, length at 2r+1).
    localparam logic [7:0] CfgEnMask  = 8'hF0;
    localparam logic [7:0] CfgLock    = 8'hF1;
    localparam logic [7:0] CfgErrCnt  = 8'hF2;
    localparam logic [7:0] CfgErrAddr = 8'hF3;
    localparam logic [7:0] CfgErrVld  = 8'hF4;

    typedef enum logic {
        CfgIdle,
        CfgResp
    } cfg_state_e;

    // Existing SoC memory map.
    localparam logic [63:0] DebugBase    = 64'h0000_0000;
    localparam logic [63:0] DebugLen     = 64'h0000_1000;
    localparam logic [63:0] RomBase      = 64'h0001_0000;
    localparam logic [63:0] RomLen       = 64'h0001_0000;
    localparam logic [63:0] ClintBase    = 64'h0200_0000;
    localparam logic [63:0] ClintLen     = 64'h000C_0000;
    localparam logic [63:0] PlicBase     = 64'h0C00_0000;
    localparam logic [63:0] PlicLen      = 64'h0400_0000;
    localparam logic [63:0] TimerBase    = 64'h1800_0000;
    localparam logic [63:0] TimerLen     = 64'h0000_1000;
    localparam logic [63:0] SpiBase      = 64'h2000_0000;
    localparam logic [63:0] SpiLen       = 64'h0080_0000;
    localparam logic [63:0] UartBase     = 64'h1000_0000;
    localparam logic [63:0] UartLen      = 64'h0000_1000;
    localparam logic [63:0] EthernetBase = 64'h3000_0000;
    localparam logic [63:0] EthernetLen  = 64'h0001_0000;
    localparam logic [63:0] GpioBase     = 64'h4000_0000;
    localparam logic [63:0] GpioLen      = 64'h0000_1000;
    localparam logic [63:0] SramBase     = 64'h0100_0000;
    localparam logic [63:0] SramLen      = 64'h0010_0000;
    localparam logic [63:0] DramBase     = 64'h8000_0000;
    localparam logic [63:0] DramLen      = 64'h4000_0000;

    localparam rule_t DefaultMap [NumSocRules] = '{
        '{base: DebugBase,    len: DebugLen,    en: 1'b1},   // 0
        '{base: RomBase,      len: RomLen,      en: 1'b1},   // 1
        '{base: ClintBase,    len: ClintLen,    en: 1'b1},   // 2
        '{base: PlicBase,     len: PlicLen,     en: 1'b1},   // 3
        '{base: TimerBase,    len: TimerLen,    en: 1'b1},   // 4
        '{base: SpiBase,      len: SpiLen,      en: 1'b1},   // 5
        '{base: UartBase,     len: UartLen,     en: 1'b1},   // 6
        '{base: EthernetBase, len: EthernetLen, en: 1'b1},   // 7
        '{base: GpioBase,     len: GpioLen,     en: 1'b1},   // 8
        '{base: SramBase,     len: SramLen,     en: 1'b1},   // 9
        '{base: DramBase,     len: DramLen,     en: 1'b1}    // 10
    };

    // True when a config word address selects rule r's base (sel_len=0)
    // or length (sel_len=1) register.
    function automatic logic cfg_rule_sel(input logic [7:0] addr,
                                          input int unsigned r,
                                          input logic sel_len);
        return addr == 8'(2 * r + int'(sel_len));
    endfunction

endpackage

// File: rtl/soc_addr_map_match.sv
// Combinational priority match of one address against the rule table.
// Returns the lowest enabled rule whose [base, base+len) window contains
// the address; idx_o = NumRules and hit_o = 0 when nothing matches.
module soc_addr_map_match
    import soc_addr_map_pkg::*;
#(
    parameter int unsigned NumRules  = NumSocRules,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxW      = $clog2(NumRules + 1)
) (
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [AddrWidth-1:0] base_i [NumRules],
    input  logic [AddrWidth-1:0] len_i  [NumRules],
    input  logic [NumRules-1:0]  en_i,
    output logic [IdxW-1:0]      idx_o,
    output logic                 hit_o
);

    // Scan upward and keep the first hit; the offset compare avoids any
    // base+len overflow and makes a zero length never hit.
    always_comb begin
        hit_o = 1'b0;
        idx_o = IdxW'(NumRules);
        for (int unsigned r = 0; r < NumRules; r++) begin
            if (!hit_o && en_i[r] && (addr_i >= base_i[r]) &&
                ((addr_i - base_i[r]) < len_i[r])) begin
                hit_o = 1'b1;
                idx_o = IdxW'(r);
            end
        end
    end

endmodule

// File: rtl/soc_addr_map_unit.sv
// Runtime-programmable SoC address decoder with a one-stage registered
// lookup pipeline, a req/gnt config port, write-once lock and a saturating
// decode-miss counter.
// Optional first-miss address capture: define ADDR_MAP_ERR_LOG_EN.
module soc_addr_map_unit
    import soc_addr_map_pkg::*;
#(
    parameter int unsigned NumRules    = 11,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned ErrCntWidth = 16,
    parameter rule_t       DefaultRules [NumRules] = DefaultMap,
    localparam int unsigned IdxW       = $clog2(NumRules + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 lk_valid_i,
    output logic                 lk_ready_o,
    input  logic [AddrWidth-1:0] lk_addr_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [IdxW-1:0]      res_idx_o,
    output logic                 res_err_o,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [7:0]           cfg_addr_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_gnt_o,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o,
    output logic                 locked_o
);

    logic [AddrWidth-1:0]   base_q [NumRules];
    logic [AddrWidth-1:0]   len_q  [NumRules];
    logic [NumRules-1:0]    en_q;
    logic                   locked_q;
    logic [ErrCntWidth-1:0] err_cnt_q;

    logic                   res_valid_q;
    logic [IdxW-1:0]        res_idx_q;
    logic                   res_err_q;

    logic [IdxW-1:0]        match_idx;
    logic                   match_hit;
    logic                   lk_accept;
    logic                   lk_miss;

    logic                   cfg_mapped;
    logic [AddrWidth-1:0]   cfg_rd_val;
    logic                   cfg_wr;
    logic                   cfg_wr_ok;
    logic                   cfg_acc_err;

    cfg_state_e             state_q, state_d;
    logic [AddrWidth-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;

`ifdef ADDR_MAP_ERR_LOG_EN
    logic [AddrWidth-1:0]   err_addr_q;
    logic                   err_vld_q;
`endif

    soc_addr_map_match #(
        .NumRules  (NumRules),
        .AddrWidth (AddrWidth),
        .IdxW      (IdxW)
    ) u_match (
        .addr_i (lk_addr_i),
        .base_i (base_q),
        .len_i  (len_q),
        .en_i   (en_q),
        .idx_o  (match_idx),
        .hit_o  (match_hit)
    );

    assign lk_ready_o = !res_valid_q || res_ready_i;
    assign lk_accept  = lk_valid_i && lk_ready_o;
    assign lk_miss    = lk_accept && !match_hit;

    // Config address decode and read-data selection.
    always_comb begin
        cfg_mapped = 1'b0;
        cfg_rd_val = '0;
        for (int unsigned r = 0; r < NumRules; r++) begin
            if (cfg_rule_sel(cfg_addr_i, r, 1'b0)) begin
                cfg_mapped = 1'b1;
                cfg_rd_val = base_q[r];
            end
            if (cfg_rule_sel(cfg_addr_i, r, 1'b1)) begin
                cfg_mapped = 1'b1;
                cfg_rd_val = len_q[r];
            end
        end
        case (cfg_addr_i)
            CfgEnMask: begin
                cfg_mapped = 1'b1;
                cfg_rd_val = AddrWidth'(en_q);
            end
            CfgLock: begin
                cfg_mapped = 1'b1;
                cfg_rd_val = AddrWidth'(locked_q);
            end
            CfgErrCnt: begin
                cfg_mapped = 1'b1;
                cfg_rd_val = AddrWidth'(err_cnt_q);
            end
`ifdef ADDR_MAP_ERR_LOG_EN
            CfgErrAddr: begin
                cfg_mapped = 1'b1;
                cfg_rd_val = err_addr_q;
            end
            CfgErrVld: begin
                cfg_mapped = 1'b1;
                cfg_rd_val = AddrWidth'(err_vld_q);
            end
`endif
            default: ;
        endcase
    end

    assign cfg_wr      = cfg_req_i && cfg_we_i;
    assign cfg_wr_ok   = cfg_wr && cfg_mapped && !locked_q;
    assign cfg_acc_err = !cfg_mapped || (cfg_wr && locked_q);

    // Rule table: reset to the default map, updated by unlocked writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned r = 0; r < NumRules; r++) begin
                base_q[r] <= DefaultRules[r].base[AddrWidth-1:0];
                len_q[r]  <= DefaultRules[r].len[AddrWidth-1:0];
                en_q[r]   <= DefaultRules[r].en;
            end
        end else if (cfg_wr_ok) begin
            for (int unsigned r = 0; r < NumRules; r++) begin
                if (cfg_rule_sel(cfg_addr_i, r, 1'b0)) base_q[r] <= cfg_wdata_i;
                if (cfg_rule_sel(cfg_addr_i, r, 1'b1)) len_q[r]  <= cfg_wdata_i;
            end
            if (cfg_addr_i == CfgEnMask) en_q <= cfg_wdata_i[NumRules-1:0];
        end
    end

    // Write-once lock: only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            locked_q <= 1'b0;
        end else if (cfg_wr_ok && (cfg_addr_i == CfgLock) && cfg_wdata_i[0]) begin
            locked_q <= 1'b1;
        end
    end

    // Saturating miss counter; a software clear takes precedence over a miss.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (cfg_wr_ok && (cfg_addr_i == CfgErrCnt)) begin
            err_cnt_q <= '0;
        end else if (lk_miss && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ErrCntWidth'(1);
        end
    end

`ifdef ADDR_MAP_ERR_LOG_EN
    // First-miss capture; held while valid, clear takes precedence.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_addr_q <= '0;
            err_vld_q  <= 1'b0;
        end else if (cfg_wr_ok && (cfg_addr_i == CfgErrVld)) begin
            err_addr_q <= '0;
            err_vld_q  <= 1'b0;
        end else if (lk_miss && !err_vld_q) begin
            err_addr_q <= lk_addr_i;
            err_vld_q  <= 1'b1;
        end
    end
`endif

    // Lookup result stage: loads on accept, drains when consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_err_q   <= 1'b0;
        end else if (lk_accept) begin
            res_valid_q <= 1'b1;
            res_idx_q   <= match_idx;
            res_err_q   <= !match_hit;
        end else if (res_ready_i) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_idx_o   = res_idx_q;
    assign res_err_o   = res_err_q;

    // Config FSM next state and response values.
    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            CfgIdle: if (cfg_req_i) state_d = CfgResp;
            CfgResp: state_d = cfg_req_i ? CfgResp : CfgIdle;
            default: state_d = CfgIdle;
        endcase
        if (cfg_req_i) begin
            rsp_rdata_d = cfg_we_i ? '0 : cfg_rd_val;
            rsp_err_d   = cfg_acc_err;
        end
    end

    // Config FSM state and registered response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= CfgIdle;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cfg_gnt_o   = cfg_req_i;
    assign cfg_rdata_o = (state_q == CfgResp) ? rsp_rdata_q : '0;
    assign cfg_err_o   = (state_q == CfgResp) ? rsp_err_q : 1'b0;
    assign locked_o    = locked_q;

endmodule

// File: tb/tb_soc_addr_map_unit.sv
// Self-checking bench for soc_addr_map_unit: directed scenarios plus a
// randomized phase, all checked against a transaction-level reference model.
module tb_soc_addr_map_unit;

    localparam int unsigned NR = 11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lk_valid, lk_ready;
    logic [63:0] lk_addr;
    logic        res_valid, res_ready;
    logic [3:0]  res_idx;
    logic        res_err;
    logic        cfg_req, cfg_we, cfg_gnt, cfg_err, locked;
    logic [7:0]  cfg_addr;
    logic [63:0] cfg_wdata, cfg_rdata;

    soc_addr_map_unit dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .lk_valid_i  (lk_valid),
        .lk_ready_o  (lk_ready),
        .lk_addr_i   (lk_addr),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_idx_o   (res_idx),
        .res_err_o   (res_err),
        .cfg_req_i   (cfg_req),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .cfg_gnt_o   (cfg_gnt),
        .cfg_rdata_o (cfg_rdata),
        .cfg_err_o   (cfg_err),
        .locked_o    (locked)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint unsigned soc_base [NR] = '{64'h0, 64'h1_0000, 64'h200_0000, 64'hC00_0000,
                                       64'h1800_0000, 64'h2000_0000, 64'h1000_0000,
                                       64'h3000_0000, 64'h4000_0000, 64'h100_0000,
                                       64'h8000_0000};
    longint unsigned soc_len  [NR] = '{64'h1000, 64'h1_0000, 64'hC_0000, 64'h400_0000,
                                       64'h1000, 64'h80_0000, 64'h1000, 64'h1_0000,
                                       64'h1000, 64'h10_0000, 64'h4000_0000};

    longint unsigned m_base [NR];
    longint unsigned m_len  [NR];
    bit [NR-1:0]     m_en;
    bit              m_locked;
    longint unsigned m_errcnt;
    longint unsigned m_elog_addr;
    bit              m_elog_vld;
    int unsigned     exp_q [$];

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_base[r] = soc_base[r];
            m_len[r]  = soc_len[r];
        end
        m_en        = '1;
        m_locked    = 1'b0;
        m_errcnt    = 0;
        m_elog_addr = 0;
        m_elog_vld  = 1'b0;
        exp_q.delete();
    endtask

    function automatic int unsigned ref_match(input longint unsigned a);
        for (int r = 0; r < NR; r++)
            if (m_en[r] && a >= m_base[r] && (a - m_base[r]) < m_len[r])
                return int'(r);
        return NR;
    endfunction

    task automatic ref_cfg(input bit we, input logic [7:0] a,
                           output logic [63:0] rd, output bit err);
        bit mapped = 1'b0;
        longint unsigned v = 0;
        if (a < 8'(2 * NR)) begin
            mapped = 1'b1;
            v = a[0] ? m_len[a >> 1] : m_base[a >> 1];
        end else begin
            case (a)
                8'hF0: begin mapped = 1'b1; v = 64'(m_en); end
                8'hF1: begin mapped = 1'b1; v = 64'(m_locked); end
                8'hF2: begin mapped = 1'b1; v = m_errcnt; end
`ifdef ADDR_MAP_ERR_LOG_EN
                8'hF3: begin mapped = 1'b1; v = m_elog_addr; end
                8'hF4: begin mapped = 1'b1; v = 64'(m_elog_vld); end
`endif
                default: ;
            endcase
        end
        err = !mapped || (we && m_locked);
        rd  = (we || !mapped) ? 64'h0 : v;
    endtask

    task automatic apply_write(input logic [7:0] a, input logic [63:0] d);
        if (a < 8'(2 * NR)) begin
            if (a[0]) m_len[a >> 1] = d;
            else      m_base[a >> 1] = d;
        end else begin
            case (a)
                8'hF0: m_en = d[NR-1:0];
                8'hF1: if (d[0]) m_locked = 1'b1;
                8'hF2: m_errcnt = 0;
                8'hF4: begin m_elog_addr = 0; m_elog_vld = 1'b0; end
                default: ;
            endcase
        end
    endtask

    // One clock cycle with the currently driven inputs; checks every
    // observable output against the model and advances the model.
    task automatic step();
        bit exp_ready, acc, miss, req, we, cerr;
        logic [7:0]  a;
        logic [63:0] wd, rd;
        int unsigned e;
        #1;
        exp_ready = (exp_q.size() == 0) || res_ready;
        check("lk_ready", 64'(lk_ready), 64'(exp_ready));
        check("res_valid", 64'(res_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("res_idx", 64'(res_idx), 64'(exp_q[0]));
            check("res_err", 64'(res_err), 64'(exp_q[0] == NR));
        end
        check("cfg_gnt", 64'(cfg_gnt), 64'(cfg_req));
        req = cfg_req; we = cfg_we; a = cfg_addr; wd = cfg_wdata;
        acc = lk_valid && exp_ready;
        if (res_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        miss = 1'b0;
        if (acc) begin
            e = ref_match(lk_addr);
            exp_q.push_back(e);
            miss = (e == NR);
        end
        rd = '0; cerr = 1'b0;
        if (req) ref_cfg(we, a, rd, cerr);
        if (miss) begin
            if (m_errcnt != 64'hFFFF) m_errcnt++;
            if (!m_elog_vld) begin m_elog_addr = lk_addr; m_elog_vld = 1'b1; end
        end
        if (req && we && !cerr) apply_write(a, wd);
        @(posedge clk); #1;
        if (req) begin
            check("cfg_err", 64'(cfg_err), 64'(cerr));
            if (!we) check("cfg_rdata", cfg_rdata, rd);
        end
        check("locked", 64'(locked), 64'(m_locked));
    endtask

    task automatic idle_inputs();
        lk_valid = 1'b0; lk_addr = '0; res_ready = 1'b1;
        cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [63:0] d);
        lk_valid = 1'b0; res_ready = 1'b1;
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_req = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [63:0] d);
        lk_valid = 1'b0; res_ready = 1'b1;
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = a; cfg_wdata = '0;
        step();
        d = cfg_rdata;
        cfg_req = 1'b0;
    endtask

    task automatic lookup(input logic [63:0] a);
        lk_valid = 1'b1; lk_addr = a; res_ready = 1'b1; cfg_req = 1'b0;
        step();
        lk_valid = 1'b0;
    endtask

    function automatic logic [63:0] pick_lk_addr();
        int unsigned r;
        r = $urandom_range(0, NR - 1);
        case ($urandom_range(0, 5))
            0:       return 64'h5000_0000 + 64'($urandom_range(0, 255));
            1:       return m_base[r] + 64'($urandom_range(0, 'h1FFF));
            2:       return {$urandom, $urandom};
            3:       return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            4:       return 64'h4000_0000 + 64'($urandom_range(0, 'h1FFF));
            default: return 64'h1000_0000 + 64'($urandom_range(0, 'h1FFF));
        endcase
    endfunction

    function automatic logic [7:0] pick_cfg_addr();
        case ($urandom_range(0, 7))
            4:       return 8'hF0;
            5:       return 8'hF2;
            6:       case ($urandom_range(0, 2))
                         0:       return 8'hF1;
                         1:       return 8'hF3;
                         default: return 8'hF4;
                     endcase
            7:       return 8'($urandom_range(0, 255));
            default: return 8'($urandom_range(0, 2 * NR - 1));
        endcase
    endfunction

    function automatic logic [63:0] pick_wdata();
        case ($urandom_range(0, 7))
            0:       return 64'h0;
            1:       return 64'h1000;
            2:       return 64'h4000_0000;
            3:       return 64'h1000_0000;
            4:       return 64'hFFFF_FFFF_FFFF_FFFF;
            5:       return 64'hFFFF_FFFF_FFFF_F000;
            6:       return 64'h2000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic [3:0]  held_idx;

        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", 64'(res_valid), 64'h0);
        check("rst_res_idx",   64'(res_idx),   64'h0);
        check("rst_res_err",   64'(res_err),   64'h0);
        check("rst_cfg_rdata", cfg_rdata,      64'h0);
        check("rst_cfg_err",   64'(cfg_err),   64'h0);
        check("rst_locked",    64'(locked),    64'h0);
        check("rst_lk_ready",  64'(lk_ready),  64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // UART hit, result visible one cycle after accept
        lookup(64'h1000_0010);
        check("uart_valid", 64'(res_valid), 64'h1);
        check("uart_idx",   64'(res_idx),   64'd6);
        check("uart_err",   64'(res_err),   64'h0);
        step();

        // two misses and the counter
        lookup(64'h5000_0000);
        check("miss1_idx", 64'(res_idx), 64'd11);
        check("miss1_err", 64'(res_err), 64'h1);
        lookup(64'h5000_0000);
        check("miss2_idx", 64'(res_idx), 64'd11);
        check("miss2_err", 64'(res_err), 64'h1);
        do_read(8'hF2, rd);
        check("errcnt_two", rd, 64'd2);

        // backpressure: hold result for 3 cycles
        lk_valid = 1'b1; lk_addr = 64'h1000_0020; res_ready = 1'b0;
        step();
        held_idx = res_idx;
        check("stall_first_idx", 64'(held_idx), 64'd6);
        lk_addr = 64'h5000_0040;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", 64'(lk_ready), 64'h0);
            step();
            check("stall_hold_idx", 64'(res_idx), 64'(held_idx));
        end
        res_ready = 1'b1;
        step();
        check("release_idx", 64'(res_idx), 64'd11);
        lk_valid = 1'b0;
        step();
        check("drained", 64'(res_valid), 64'h0);

        // overlapping rules 2 and 3, priority and enable
        do_write(8'd4, 64'h4000_0000);
        do_write(8'd5, 64'h1000);
        do_write(8'd6, 64'h4000_0000);
        do_write(8'd7, 64'h1000);
        do_write(8'hF0, 64'h7FB);
        lookup(64'h4000_0000);
        check("overlap_en2_off", 64'(res_idx), 64'd3);
        do_write(8'hF0, 64'h7FF);
        lookup(64'h4000_0000);
        check("overlap_en2_on", 64'(res_idx), 64'd2);

        // counter saturation
        do_write(8'hF2, 64'h1234);
        lk_valid = 1'b1; lk_addr = 64'h5000_0000; res_ready = 1'b1;
        for (int i = 0; i < 65535; i++) step();
        lk_valid = 1'b0;
        do_read(8'hF2, rd);
        check("errcnt_full", rd, 64'hFFFF);
        lookup(64'h5000_0000);
        do_read(8'hF2, rd);
        check("errcnt_sat", rd, 64'hFFFF);

`ifdef ADDR_MAP_ERR_LOG_EN
        do_write(8'hF4, 64'h0);
        lookup(64'h5000_0000);
        lookup(64'h6000_0000);
        do_read(8'hF3, rd);
        check("elog_addr", rd, 64'h5000_0000);
        do_read(8'hF4, rd);
        check("elog_vld", rd, 64'h1);
`endif

        // randomized traffic on both ports (lock never set here)
        for (int i = 0; i < 600; i++) begin
            lk_valid  = ($urandom_range(0, 2) != 0);
            lk_addr   = pick_lk_addr();
            res_ready = ($urandom_range(0, 3) != 0);
            cfg_req   = ($urandom_range(0, 1) == 1);
            cfg_we    = ($urandom_range(0, 1) == 1);
            cfg_addr  = pick_cfg_addr();
            cfg_wdata = pick_wdata();
            if (cfg_addr == 8'hF1) cfg_wdata = '0;
            step();
        end
        idle_inputs();
        step();

        // restore the SoC map, then the lock scenario
        for (int r = 0; r < NR; r++) begin
            do_write(8'(2 * r), soc_base[r]);
            do_write(8'(2 * r + 1), soc_len[r]);
        end
        do_write(8'hF0, 64'h7FF);
        do_write(8'd13, 64'h0);
        lookup(64'h1000_0010);
        check("len0_miss", 64'(res_idx), 64'd11);
        do_write(8'hF1, 64'h1);
        check("lock_set", 64'(locked), 64'h1);
        do_write(8'd13, 64'h1000);
        check("locked_wr_err", 64'(cfg_err), 64'h1);
        lookup(64'h1000_0010);
        check("locked_still_miss", 64'(res_idx), 64'd11);
        do_write(8'hF1, 64'h0);
        check("lock_sticky", 64'(locked), 64'h1);
        do_read(8'd13, rd);
        check("locked_len_read", rd, 64'h0);
        check("locked_read_ok", 64'(cfg_err), 64'h0);
        do_read(8'hF9, rd);
        check("unmapped_err", 64'(cfg_err), 64'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
